// File: rtl/ctl_game_pkg.sv
// Shared types and widths for the Duck Hunt game sequencer.
package ctl_game_pkg;

  localparam int TIMER_W = 7;
  localparam int ROUND_W = 7;
  localparam int DUCK_W  = 4;
  localparam int SHOT_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    FLIGHT,
    HIT,
    ESCAPE,
    ROUND_END,
    GAME_OVER
  } game_state_t;

  // States in which pause_req freezes the sequencer.
  function automatic logic is_pausable(input game_state_t s);
    return (s == FLIGHT) || (s == HIT) || (s == ESCAPE) || (s == ROUND_END);
  endfunction

endpackage

// File: rtl/ctl_game_frame_timer.sv
// Frame-pulse counter with clear, pause gate and terminal-count compare.
module frame_timer
  import ctl_game_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_en,
  input  logic               i_tick,
  input  logic [TIMER_W-1:0] i_tc,
  output logic               o_done
);

  logic [TIMER_W-1:0] r_count;
  logic               w_step;

  assign w_step = i_en & i_tick;
  // Fires on the frame that brings the count up to i_tc.
  assign o_done = w_step & (r_count == (i_tc - TIMER_W'(1)));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clear || o_done) begin
      r_count <= '0;
    end else if (w_step) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/ctl_game.sv
// Duck Hunt round/duck sequencer: launches ducks, counts shots and hits,
// decides pass or game over, and drives overlay flags and clear pulses.
//
// state     | meaning
// IDLE      | after reset, waiting for start
// LAUNCH    | one cycle, fires duck_launch and reloads shots
// FLIGHT    | duck on screen, shots and hits counted
// HIT       | duck shot, hold for HIT_HOLD_FRAMES
// ESCAPE    | duck lost, hold for ESCAPE_FRAMES
// ROUND_END | gap of ROUND_GAP_FRAMES, then pass or game over
// GAME_OVER | loser overlay, waiting for start
module ctl_game
  import ctl_game_pkg::*;
#(
  parameter int DUCKS_PER_ROUND  = 10,
  parameter int PASS_HITS        = 6,
  parameter int SHOTS_PER_DUCK   = 3,
  parameter int HIT_HOLD_FRAMES  = 60,
  parameter int ESCAPE_FRAMES    = 90,
  parameter int ROUND_GAP_FRAMES = 120,
  parameter int MAX_ROUND        = 99
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_new_frame,
  input  logic               i_start_btn,
  input  logic               i_pause_req,
  input  logic               i_hit,
  input  logic               i_shot_fired,
  input  logic               i_duck_gone,
  output logic               o_duck_launch,
  output logic               o_duck_active,
  output logic [SHOT_W-1:0]  o_shots_left,
  output logic [ROUND_W-1:0] o_round,
  output logic [DUCK_W-1:0]  o_ducks_done,
  output logic [DUCK_W-1:0]  o_ducks_hit,
  output logic               o_pause,
  output logic               o_game_over,
  output logic               o_clear_score
);

  localparam logic [DUCK_W-1:0]  DUCKS_L = DUCK_W'(DUCKS_PER_ROUND);
  localparam logic [DUCK_W-1:0]  PASS_L  = DUCK_W'(PASS_HITS);
  localparam logic [SHOT_W-1:0]  SHOTS_L = SHOT_W'(SHOTS_PER_DUCK);
  localparam logic [ROUND_W-1:0] MAXR_L  = ROUND_W'(MAX_ROUND);

  game_state_t        r_state;
  game_state_t        w_state_nxt;
  logic               r_start_d;

  logic               r_duck_launch, w_duck_launch_nxt;
  logic               r_duck_active, w_duck_active_nxt;
  logic [SHOT_W-1:0]  r_shots_left, w_shots_left_nxt;
  logic [ROUND_W-1:0] r_round, w_round_nxt;
  logic [DUCK_W-1:0]  r_ducks_done, w_ducks_done_nxt;
  logic [DUCK_W-1:0]  r_ducks_hit, w_ducks_hit_nxt;
  logic               r_pause, w_pause_nxt;
  logic               r_game_over, w_game_over_nxt;
  logic               r_clear_score, w_clear_score_nxt;

  logic               w_start_edge;
  logic               w_freeze;
  logic               w_hit;
  logic               w_shot;
  logic               w_gone;
  logic               w_timed;
  logic               w_expire;
  logic               w_pass;
  logic               w_start_game;
  logic               w_round_adv;
  logic [DUCK_W-1:0]  w_done_inc;
  logic [TIMER_W-1:0] w_tc;

  assign w_start_edge = i_start_btn & ~r_start_d;
  assign w_freeze     = i_pause_req & is_pausable(r_state);
  // Gated events: everything is ignored while frozen; a hit needs a live shot.
  assign w_hit        = i_hit & ~w_freeze & (r_shots_left != '0);
  assign w_shot       = i_shot_fired & ~w_freeze;
  assign w_gone       = i_duck_gone & ~w_freeze;
  assign w_timed      = (r_state == HIT) || (r_state == ESCAPE) || (r_state == ROUND_END);
  assign w_pass       = (r_ducks_hit >= PASS_L);
  assign w_done_inc   = r_ducks_done + DUCK_W'(1);
  assign w_start_game = w_start_edge & ((r_state == IDLE) || (r_state == GAME_OVER));
  assign w_round_adv  = (r_state == ROUND_END) & w_expire & w_pass;

  always_comb begin
    w_tc = TIMER_W'(ROUND_GAP_FRAMES);
    case (r_state)
      HIT:     w_tc = TIMER_W'(HIT_HOLD_FRAMES);
      ESCAPE:  w_tc = TIMER_W'(ESCAPE_FRAMES);
      default: w_tc = TIMER_W'(ROUND_GAP_FRAMES);
    endcase
  end

  frame_timer u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_state_nxt != r_state),
    .i_en    (w_timed & ~w_freeze),
    .i_tick  (i_new_frame),
    .i_tc    (w_tc),
    .o_done  (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= i_start_btn;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, GAME_OVER: begin
        if (w_start_edge) w_state_nxt = LAUNCH;
      end
      LAUNCH: w_state_nxt = FLIGHT;
      FLIGHT: begin
        if (w_hit) begin
          w_state_nxt = HIT;
        end else if (w_gone || (w_shot && (r_shots_left == SHOT_W'(1)))) begin
          w_state_nxt = ESCAPE;
        end
      end
      HIT, ESCAPE: begin
        if (w_expire) w_state_nxt = (w_done_inc == DUCKS_L) ? ROUND_END : LAUNCH;
      end
      ROUND_END: begin
        if (w_expire) w_state_nxt = w_pass ? LAUNCH : GAME_OVER;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_duck_launch_nxt = (r_state == LAUNCH);
    w_duck_active_nxt = (w_state_nxt == FLIGHT) & ~w_freeze;
    w_pause_nxt       = w_freeze;
    w_game_over_nxt   = (w_state_nxt == GAME_OVER);
    w_clear_score_nxt = w_start_game | w_round_adv;
    w_round_nxt       = r_round;
    w_ducks_done_nxt  = r_ducks_done;
    w_ducks_hit_nxt   = r_ducks_hit;
    w_shots_left_nxt  = r_shots_left;

    if (w_start_game) begin
      w_round_nxt      = ROUND_W'(1);
      w_ducks_done_nxt = '0;
      w_ducks_hit_nxt  = '0;
    end else if (w_round_adv) begin
      w_round_nxt      = (r_round >= MAXR_L) ? MAXR_L : r_round + ROUND_W'(1);
      w_ducks_done_nxt = '0;
      w_ducks_hit_nxt  = '0;
    end else if (((r_state == HIT) || (r_state == ESCAPE)) && w_expire) begin
      w_ducks_done_nxt = w_done_inc;
    end

    if (r_state == LAUNCH) begin
      w_shots_left_nxt = SHOTS_L;
    end else if (r_state == FLIGHT) begin
      if (w_shot && (r_shots_left != '0)) w_shots_left_nxt = r_shots_left - SHOT_W'(1);
      if (w_hit) w_ducks_hit_nxt = r_ducks_hit + DUCK_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_duck_launch <= 1'b0;
      r_duck_active <= 1'b0;
      r_shots_left  <= '0;
      r_round       <= ROUND_W'(1);
      r_ducks_done  <= '0;
      r_ducks_hit   <= '0;
      r_pause       <= 1'b0;
      r_game_over   <= 1'b0;
      r_clear_score <= 1'b0;
    end else begin
      r_duck_launch <= w_duck_launch_nxt;
      r_duck_active <= w_duck_active_nxt;
      r_shots_left  <= w_shots_left_nxt;
      r_round       <= w_round_nxt;
      r_ducks_done  <= w_ducks_done_nxt;
      r_ducks_hit   <= w_ducks_hit_nxt;
      r_pause       <= w_pause_nxt;
      r_game_over   <= w_game_over_nxt;
      r_clear_score <= w_clear_score_nxt;
    end
  end

  assign o_duck_launch = r_duck_launch;
  assign o_duck_active = r_duck_active;
  assign o_shots_left  = r_shots_left;
  assign o_round       = r_round;
  assign o_ducks_done  = r_ducks_done;
  assign o_ducks_hit   = r_ducks_hit;
  assign o_pause       = r_pause;
  assign o_game_over   = r_game_over;
  assign o_clear_score = r_clear_score;

endmodule

// File: tb/tb_ctl_game.sv
// Bench for ctl_game: directed scenarios plus randomized play, checked every
// cycle against a phase/frames-remaining model of the game rules.
module tb_ctl_game;

  localparam int DPR = 10, PASS = 6, SPD = 3;
  localparam int HIT_F = 60, ESC_F = 90, GAP_F = 120, MAXR = 3;

  localparam int P_IDLE = 0, P_LAUNCH = 1, P_FLIGHT = 2, P_HIT = 3;
  localparam int P_ESC = 4, P_GAP = 5, P_OVER = 6;

  localparam int W_CLEAR = 0, W_OVER = 1, W_ACTIVE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic new_frame = 1'b0, start_btn = 1'b0, pause_req = 1'b0;
  logic hit = 1'b0, shot_fired = 1'b0, duck_gone = 1'b0;
  logic duck_launch, duck_active, pause, game_over, clear_score;
  logic [1:0] shots_left;
  logic [6:0] round;
  logic [3:0] ducks_done, ducks_hit;

  int n_checks = 0, n_errors = 0;

  // model state
  int m_ph = P_IDLE, m_left = 0, m_round = 1, m_done = 0, m_hits = 0, m_shots = 0;
  bit m_btn_prev = 0;
  bit e_launch = 0, e_active = 0, e_pause = 0, e_over = 0, e_clear = 0;

  // random policy
  int g_hits_target = 0, g_pause_left = 0;
  bit g_pause_en = 0;

  always #5 clk = ~clk;

  ctl_game #(
    .DUCKS_PER_ROUND(DPR), .PASS_HITS(PASS), .SHOTS_PER_DUCK(SPD),
    .HIT_HOLD_FRAMES(HIT_F), .ESCAPE_FRAMES(ESC_F), .ROUND_GAP_FRAMES(GAP_F),
    .MAX_ROUND(MAXR)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_new_frame(new_frame), .i_start_btn(start_btn),
    .i_pause_req(pause_req), .i_hit(hit), .i_shot_fired(shot_fired),
    .i_duck_gone(duck_gone), .o_duck_launch(duck_launch), .o_duck_active(duck_active),
    .o_shots_left(shots_left), .o_round(round), .o_ducks_done(ducks_done),
    .o_ducks_hit(ducks_hit), .o_pause(pause), .o_game_over(game_over),
    .o_clear_score(clear_score)
  );

  function automatic int hold_of(int ph);
    case (ph)
      P_HIT:   return HIT_F;
      P_ESC:   return ESC_F;
      P_GAP:   return GAP_F;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_timer();
    return hold_of(m_ph) == 0 ? 0 : hold_of(m_ph) - m_left;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Game rules applied to the inputs present at the coming clock edge.
  task automatic model_step();
    int nxt;
    bit edge_s, frz, shot_now;
    if (!rst) begin
      m_ph = P_IDLE; m_left = 0; m_round = 1; m_done = 0; m_hits = 0; m_shots = 0;
      m_btn_prev = 0;
      e_launch = 0; e_active = 0; e_pause = 0; e_over = 0; e_clear = 0;
      return;
    end
    edge_s = start_btn && !m_btn_prev;
    m_btn_prev = start_btn;
    frz = pause_req && (m_ph == P_FLIGHT || m_ph == P_HIT || m_ph == P_ESC || m_ph == P_GAP);
    nxt = m_ph;
    e_clear = 0;
    e_launch = 0;
    case (m_ph)
      P_IDLE, P_OVER: if (edge_s) begin
        e_clear = 1; m_round = 1; m_done = 0; m_hits = 0; nxt = P_LAUNCH;
      end
      P_LAUNCH: begin
        e_launch = 1; m_shots = SPD; nxt = P_FLIGHT;
      end
      P_FLIGHT: if (!frz) begin
        shot_now = shot_fired && m_shots > 0;
        if (hit && m_shots > 0) begin
          m_hits++;
          nxt = P_HIT;
        end else if (duck_gone || (shot_now && m_shots == 1)) begin
          nxt = P_ESC;
        end
        if (shot_now) m_shots--;
      end
      P_HIT, P_ESC, P_GAP: if (!frz && new_frame) begin
        m_left--;
        if (m_left == 0) begin
          if (m_ph == P_GAP) begin
            if (m_hits >= PASS) begin
              m_round = (m_round + 1 > MAXR) ? MAXR : m_round + 1;
              m_done = 0; m_hits = 0; e_clear = 1; nxt = P_LAUNCH;
            end else begin
              nxt = P_OVER;
            end
          end else begin
            m_done++;
            nxt = (m_done == DPR) ? P_GAP : P_LAUNCH;
          end
        end
      end
      default: nxt = P_IDLE;
    endcase
    if (nxt != m_ph) m_left = hold_of(nxt);
    e_pause = frz;
    e_active = (nxt == P_FLIGHT) && !frz;
    e_over = (nxt == P_OVER);
    m_ph = nxt;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("duck_launch", duck_launch, e_launch);
    chk("duck_active", duck_active, e_active);
    chk("shots_left", shots_left, m_shots);
    chk("round", round, m_round);
    chk("ducks_done", ducks_done, m_done);
    chk("ducks_hit", ducks_hit, m_hits);
    chk("pause", pause, e_pause);
    chk("game_over", game_over, e_over);
    chk("clear_score", clear_score, e_clear);
    chk("frame_timer", dut.u_timer.r_count, exp_timer());
  endtask

  task automatic quiet();
    hit = 0; shot_fired = 0; duck_gone = 0; new_frame = 0; pause_req = 0;
  endtask

  task automatic drive_auto();
    hit = 0; shot_fired = 0; duck_gone = 0;
    new_frame = ($urandom_range(0, 3) != 0);
    if (g_pause_left > 0) begin
      pause_req = 1;
      g_pause_left--;
    end else begin
      pause_req = 0;
      if (g_pause_en && $urandom_range(0, 199) == 0) g_pause_left = $urandom_range(1, 40);
    end
    if (m_ph == P_FLIGHT) begin
      if ($urandom_range(0, 3) == 0) begin
        if (m_hits < g_hits_target) begin
          hit = 1;
          shot_fired = $urandom_range(0, 1);
        end else if ($urandom_range(0, 4) == 0) begin
          duck_gone = 1;
        end else begin
          shot_fired = 1;
        end
      end
    end else if ($urandom_range(0, 15) == 0) begin
      hit = 1; shot_fired = 1; duck_gone = $urandom_range(0, 1);
    end
  endtask

  task automatic run_until(input int which, input int budget, input string what);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < budget) begin
      drive_auto();
      cycle();
      n++;
      case (which)
        W_CLEAR: seen = clear_score;
        W_OVER:  seen = game_over;
        default: seen = duck_active;
      endcase
    end
    chk({"reached_", what}, seen, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames;
    rst = 0;
    quiet();
    repeat (3) cycle();
    chk("rst_round", round, 1);
    chk("rst_shots", shots_left, 0);
    chk("rst_game_over", game_over, 0);
    rst = 1;

    // junk while idle: nothing may move
    for (int i = 0; i < 8; i++) begin
      hit = $urandom_range(0, 1); shot_fired = $urandom_range(0, 1);
      duck_gone = $urandom_range(0, 1); pause_req = 1; new_frame = 1;
      cycle();
    end
    chk("idle_pause", pause, 0);
    quiet();

    // start: clear pulse, then launch two cycles after the edge
    start_btn = 1;
    cycle();
    chk("start_clear", clear_score, 1);
    cycle();
    chk("start_launch", duck_launch, 1);
    chk("start_shots", shots_left, 3);
    chk("start_round", round, 1);
    start_btn = 0;

    // three misses -> escape, 90 frames
    shot_fired = 1; cycle(); chk("shot1", shots_left, 2);
    shot_fired = 0; cycle();
    shot_fired = 1; cycle(); chk("shot2", shots_left, 1);
    shot_fired = 1; cycle(); chk("shot3_inactive", duck_active, 0);
    shot_fired = 0; new_frame = 1;
    frames = 0;
    while (ducks_done != 1 && frames < 200) begin cycle(); frames++; end
    chk("escape_frames", frames, 90);
    new_frame = 0;
    cycle();
    chk("relaunch", duck_launch, 1);

    // hit together with the last shot -> HIT, 60 frames
    shot_fired = 1; cycle();
    shot_fired = 1; cycle();
    chk("pre_last_shot", shots_left, 1);
    hit = 1; shot_fired = 1; cycle();
    chk("hitshot_hits", ducks_hit, 1);
    chk("hitshot_shots", shots_left, 0);
    quiet(); new_frame = 1;
    frames = 0;
    while (ducks_done != 2 && frames < 200) begin cycle(); frames++; end
    chk("hit_frames", frames, 60);
    new_frame = 0;
    cycle();
    cycle();

    // pause mid-HIT at timer 30
    hit = 1; cycle();
    hit = 0; new_frame = 1;
    repeat (30) cycle();
    chk("timer_before_pause", dut.u_timer.r_count, 30);
    pause_req = 1;
    for (int i = 0; i < 500; i++) begin
      new_frame = i[0];
      hit = (i == 250);
      cycle();
    end
    chk("paused_flag", pause, 1);
    chk("paused_timer", dut.u_timer.r_count, 30);
    chk("paused_hits", ducks_hit, 2);
    quiet(); new_frame = 1;
    frames = 0;
    while (ducks_done != 3 && frames < 200) begin cycle(); frames++; end
    chk("resume_frames", frames, 30);

    // random play: round 1 passes, round 2 fails
    g_pause_en = 1;
    g_hits_target = 6;
    run_until(W_CLEAR, 6000, "round1_pass");
    chk("round2_num", round, 2);
    chk("round2_done", ducks_done, 0);
    g_hits_target = 5;
    run_until(W_OVER, 6000, "round2_fail");
    chk("over_round", round, 2);
    for (int i = 0; i < 5; i++) begin quiet(); pause_req = 1; new_frame = 1; cycle(); end
    chk("over_holds", game_over, 1);
    quiet();
    start_btn = 1;
    cycle();
    chk("restart_clear", clear_score, 1);
    chk("restart_round", round, 1);
    chk("restart_over", game_over, 0);
    start_btn = 0;

    // climb to the round cap and saturate
    g_hits_target = 10;
    run_until(W_CLEAR, 6000, "to_round2");
    g_hits_target = 7;
    run_until(W_CLEAR, 6000, "to_round3");
    chk("round3", round, 3);
    g_hits_target = 8;
    run_until(W_CLEAR, 6000, "round_sat");
    chk("round_saturated", round, 3);

    // reset mid-flight
    run_until(W_ACTIVE, 200, "flight_r3");
    rst = 0;
    quiet();
    cycle();
    chk("midrst_round", round, 1);
    chk("midrst_active", duck_active, 0);
    chk("midrst_done", ducks_done, 0);
    chk("midrst_hits", ducks_hit, 0);
    rst = 1;
    repeat (5) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ctl_game.md
Name: ctl_game

Overview:
Top-level game sequencer for Duck Hunt. Runs the round/duck life cycle: launches each duck, counts shots per duck, and tallies hits per round. At round end it decides pass or game over, and it drives pause/loser overlay flags plus clear pulses for score and ammo. It sits in the ctrl section between ctl_trigger (hit, shot_fired) and ctl_duck/ctl_score/ctl_ammo/draw_overlay, replacing the hard-wired test_btn and switch controls.

Parameters:
DUCKS_PER_ROUND, 10, ducks launched per round (1..15)
PASS_HITS, 6, minimum hits in a round to advance (<= DUCKS_PER_ROUND)
SHOTS_PER_DUCK, 3, shots allowed per duck (1..3)
HIT_HOLD_FRAMES, 60, frames spent in HIT before next duck
ESCAPE_FRAMES, 90, frames spent in ESCAPE before next duck
ROUND_GAP_FRAMES, 120, frames spent in ROUND_END
MAX_ROUND, 99, round counter saturates here

Ports:
clk  in  1  65 MHz system clock
rst  in  1  reset: synchronous and active-low
new_frame  in  1  one-cycle pulse per VGA frame; all frame timers advance on it
start_btn  in  1  debounced level; rising edge detected internally
pause_req  in  1  level; requests freeze
hit  in  1  one-cycle pulse: duck hit
shot_fired  in  1  one-cycle pulse: any shot
duck_gone  in  1  one-cycle pulse: duck left the screen unhit
duck_launch  out  1  one-cycle pulse: start a new duck
duck_active  out  1  high while in FLIGHT
shots_left  out  2  remaining shots for the current duck
round  out  7  current round, 1..MAX_ROUND
ducks_done  out  4  ducks finished in this round
ducks_hit  out  4  ducks hit in this round
pause  out  1  overlay pause flag
game_over  out  1  overlay loser flag
clear_score  out  1  one-cycle pulse: reset score and ammo

Behaviour:
- All outputs are registered.
- Reset (rst==0 on a clk edge): state=IDLE; round=1; ducks_done=0; ducks_hit=0; shots_left=0; all pulses 0; pause=0; game_over=0; frame timer=0. Reset mid-operation aborts any state immediately.
- start_edge = start_btn & ~start_btn_d (registered delay).
- IDLE: on start_edge, assert clear_score for one cycle, load round=1, ducks_done=0, ducks_hit=0, then go to LAUNCH.
- LAUNCH (1 cycle): duck_launch=1, shots_left=SHOTS_PER_DUCK, then go to FLIGHT.
- FLIGHT: duck_active=1.
  - hit -> ducks_hit+1, go to HIT.
  - else duck_gone -> ESCAPE.
  - shot_fired decrements shots_left (saturates at 0).
  - shot_fired with shots_left==1 and no hit in the same cycle -> ESCAPE.
  - hit and shot_fired in the same cycle: hit wins and the shot is still decremented.
  - hit while shots_left==0 is impossible by construction; ignore it.
- HIT / ESCAPE: the timer counts new_frame pulses up to HIT_HOLD_FRAMES / ESCAPE_FRAMES. When it expires, ducks_done+1 and the timer clears. Then:
  - if ducks_done (new value) == DUCKS_PER_ROUND -> ROUND_END;
  - else -> LAUNCH.
  - hit, shot_fired and duck_gone are ignored in these states.
- ROUND_END: wait ROUND_GAP_FRAMES frames, then:
  - if ducks_hit >= PASS_HITS: round=min(round+1, MAX_ROUND), ducks_done=0, ducks_hit=0, clear_score pulse (ammo refill), go to LAUNCH.
  - else -> GAME_OVER.
- GAME_OVER: game_over=1. On start_edge, behave as the IDLE start: clear counters, pulse clear_score, go to LAUNCH with game_over=0.
- PAUSE:
  - Condition: pause_req=1 while in FLIGHT/HIT/ESCAPE/ROUND_END.
  - Effect: pause=1 in the next cycle, state and timer frozen, and hit/shot_fired/duck_gone/start_edge ignored. duck_active is forced to 0 while paused.
  - On release (pause_req=0), resume the same state with the same timer value.
  - pause_req in IDLE, LAUNCH or GAME_OVER has no effect; if held through LAUNCH, pause takes effect in the next state.
- Counter widths: ducks_done and ducks_hit are 4 bits and never exceed DUCKS_PER_ROUND. The frame timer is 7 bits, sized for the largest frame parameter; it is cleared on every state entry.
- Latency: input pulse to state change is 1 cycle; duck_launch occurs exactly 1 cycle after entering LAUNCH.

Decomposition:
- Package ctl_game_pkg: enum game_state_t {IDLE, LAUNCH, FLIGHT, HIT, ESCAPE, ROUND_END, GAME_OVER}, and the width localparams (timer 7, round 7, duck count 4).
- One sub-module, frame_timer: counts new_frame pulses, with clear, enable (the pause gate) and a terminal-count compare input.
- Everything else lives in a single FSM module.

Test Plan:
- Reset then start_edge -> clear_score pulse; duck_launch 2 cycles after the edge; shots_left=3; round=1.
- FLIGHT with 3 shot_fired pulses and no hit -> shots_left 2,1, then ESCAPE; after 90 new_frames ducks_done=1 and duck_launch pulses again.
- hit and shot_fired in the same cycle with shots_left=1 -> HIT (not ESCAPE); ducks_hit=1; shots_left=0; after 60 frames ducks_done=1.
- 10 ducks with 6 hits -> ROUND_END; after 120 frames round=2, counters=0, clear_score pulse. With 5 hits instead -> game_over=1; a later start_edge restarts at round=1.
- pause_req held 500 cycles during HIT at timer=30 -> pause=1; timer stays at 30 across new_frames; a hit pulse is ignored; after release HIT ends 30 frames later.
- rst=0 asserted mid-FLIGHT at round=3 -> next edge: IDLE, round=1, all outputs at their reset values.
